// File: rtl/rv32i_tb_pkg.sv
// Shared definitions for the RV32I test-harness monitor blocks.
// Holds the monitor FSM state type, the store-event record and the default
// XLEN / tohost mailbox / watchdog constants used by rv_store_monitor and
// its bench. No ports: package only.
package rv32i_tb_pkg;

  localparam int unsigned XLEN_DEFAULT           = 32;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT    = 32'h8000_0000;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200_000;
  localparam int unsigned FIFO_DEPTH_DEFAULT     = 8;

  // RUN is the only live state; the other three hold until reset.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  // One observed store as carried through the event stream.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] addr;
    logic [XLEN_DEFAULT-1:0] data;
  } store_event_t;

  function automatic logic is_terminal(input mon_state_e s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/rv_event_fifo.sv
// Synchronous FIFO for store events.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (empties FIFO)
//   push_i, wdata_i     write request and data; ignored when full unless a
//                       pop happens in the same cycle
//   pop_i               read request; ignored when empty
//   rdata_o             head entry (valid while empty_o is low)
//   full_o, empty_o     occupancy flags
// Pointers carry one extra wrap bit so full and empty stay distinguishable
// when the index bits coincide.
module rv_event_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             pop_ok, push_ok;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_idx == rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  // when the consumer is draining.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (push_ok && (wr_idx == AW'(gi))) mem_q[gi] <= wdata_i;
    end
  end

  // Head read straight from storage: an entry written on one edge is
  // presented after that edge, never on the same cycle it is pushed.
  assign rdata_o = mem_q[rd_idx];

endmodule

// File: rtl/rv_store_monitor.sv
// Store monitor for RISC-V test programs.
// Watches the core's store port, ends the test when the program writes the
// tohost mailbox (data 1 = pass, other odd data = fail with code data>>1),
// ends it on a cycle watchdog, and streams every store seen while running
// out through a valid/ready event FIFO.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   st_valid_i, st_addr_i, st_data_i     observed store
//   ev_valid_o, ev_ready_i,
//   ev_addr_o, ev_data_o                 store event stream
//   done_o, pass_o, fail_o, timeout_o    test status
//   overflow_o, drop_count_o             sticky FIFO overflow, dropped events
//   fail_code_o                          failure code from the mailbox
//   cycle_count_o                        cycles spent running (saturating)
module rv_store_monitor
  import rv32i_tb_pkg::*;
#(
  parameter int unsigned     XLEN           = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned     FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int unsigned     TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            st_valid_i,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic            ev_valid_o,
  input  logic            ev_ready_i,
  output logic [XLEN-1:0] ev_addr_o,
  output logic [XLEN-1:0] ev_data_o,
  output logic            done_o,
  output logic            pass_o,
  output logic            fail_o,
  output logic            timeout_o,
  output logic            overflow_o,
  output logic [XLEN-2:0] fail_code_o,
  output logic [31:0]     cycle_count_o,
  output logic [15:0]     drop_count_o
);

  // Count value on which the watchdog fires; unused when disabled.
  localparam logic [31:0] WD_LIMIT =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  mon_state_e      state_q, state_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [XLEN-2:0] fail_code_q, fail_code_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_count_q, drop_count_d;

  logic              in_run;
  logic              st_push;
  logic              term_store;
  logic              wd_hit;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic [2*XLEN-1:0] fifo_rdata;

  assign in_run  = (state_q == ST_RUN);
  assign st_push = st_valid_i && in_run;
  // Even data to tohost is an ordinary store; only odd data ends the test.
  assign term_store = st_push && (st_addr_i == TOHOST_ADDR) && st_data_i[0];
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_q == WD_LIMIT);
  // Full with no pop this cycle means the event is lost.
  assign fifo_drop = st_push && fifo_full && !ev_ready_i;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // A terminating store beats the watchdog on the same cycle.
  always_comb begin
    state_d = state_q;
    if (in_run) begin
      if (term_store)  state_d = (st_data_i == XLEN'(1)) ? ST_PASS : ST_FAIL;
      else if (wd_hit) state_d = ST_TIMEOUT;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    done_o    = is_terminal(state_q);
    pass_o    = (state_q == ST_PASS);
    fail_o    = (state_q == ST_FAIL);
    timeout_o = (state_q == ST_TIMEOUT);
  end

  // ---------------- counters and latched status ----------------
  always_comb begin
    cycle_count_d = cycle_count_q;
    fail_code_d   = fail_code_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;
    if (in_run && (cycle_count_q != 32'hFFFF_FFFF))
      cycle_count_d = cycle_count_q + 32'd1;
    if (term_store && (st_data_i != XLEN'(1)))
      fail_code_d = st_data_i[XLEN-1:1];
    if (fifo_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_count_q <= '0;
      fail_code_q   <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      fail_code_q   <= fail_code_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign cycle_count_o = cycle_count_q;
  assign fail_code_o   = fail_code_q;
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_count_q;

  // ---------------- event stream ----------------
  rv_event_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (st_push),
    .wdata_i ({st_addr_i, st_data_i}),
    .pop_i   (ev_ready_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid_o = !fifo_empty;
  assign ev_addr_o  = fifo_rdata[2*XLEN-1:XLEN];
  assign ev_data_o  = fifo_rdata[XLEN-1:0];

endmodule

// File: tb/tb_rv_store_monitor.sv
// Self-checking bench for rv_store_monitor (FIFO_DEPTH=4, TIMEOUT_CYCLES=50).
// A queue-based reference model is updated on every rising edge from the
// applied inputs; a negedge process compares every DUT output against it.
// Directed scenarios add literal expectations computed by hand.
module tb_rv_store_monitor;
  import rv32i_tb_pkg::*;

  localparam logic [31:0] TOHOST = 32'h8000_0000;
  localparam int          DEPTH  = 4;
  localparam longint      TMO    = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid_o;
  logic [31:0] ev_addr_o, ev_data_o;
  logic        done_o, pass_o, fail_o, timeout_o, overflow_o;
  logic [30:0] fail_code_o;
  logic [31:0] cycle_count_o;
  logic [15:0] drop_count_o;

  always #5 clk = ~clk;

  rv_store_monitor #(
    .XLEN           (32),
    .TOHOST_ADDR    (TOHOST),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (50)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .st_valid_i    (st_valid),
    .st_addr_i     (st_addr),
    .st_data_i     (st_data),
    .ev_valid_o    (ev_valid_o),
    .ev_ready_i    (ev_ready),
    .ev_addr_o     (ev_addr_o),
    .ev_data_o     (ev_data_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .overflow_o    (overflow_o),
    .fail_code_o   (fail_code_o),
    .cycle_count_o (cycle_count_o),
    .drop_count_o  (drop_count_o)
  );

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  store_event_t m_q[$];
  bit          m_pass, m_fail, m_tmo, m_ovf;
  logic [30:0] m_code;
  longint      m_cycles;
  int          m_drops;
  bit          m_run, m_pop, m_push;
  int          m_occ;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pass = 0; m_fail = 0; m_tmo = 0; m_ovf = 0;
      m_code = '0; m_cycles = 0; m_drops = 0;
    end else begin
      m_run  = !(m_pass || m_fail || m_tmo);
      m_occ  = m_q.size();
      m_pop  = (m_occ > 0) && ev_ready;
      m_push = st_valid && m_run;
      if (m_run) begin
        if (st_valid && st_addr == TOHOST && st_data[0]) begin
          if (st_data == 32'd1) m_pass = 1;
          else begin
            m_fail = 1;
            m_code = st_data[31:1];
          end
        end else if (m_cycles == TMO - 1) begin
          m_tmo = 1;
        end
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_occ == DEPTH && !m_pop) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_q.push_back('{addr: st_addr, data: st_data});
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("ev_valid", 64'(ev_valid_o), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("ev_addr", 64'(ev_addr_o), 64'(m_q[0].addr));
        chk("ev_data", 64'(ev_data_o), 64'(m_q[0].data));
      end
      chk("done", 64'(done_o), 64'(m_pass || m_fail || m_tmo));
      chk("pass", 64'(pass_o), 64'(m_pass));
      chk("fail", 64'(fail_o), 64'(m_fail));
      chk("timeout", 64'(timeout_o), 64'(m_tmo));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("fail_code", 64'(fail_code_o), 64'(m_code));
      chk("cycle_count", 64'(cycle_count_o), 64'(m_cycles));
      chk("drop_count", 64'(drop_count_o), 64'(m_drops));
      if (ev_valid_o && ev_ready) rx_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    st_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    ev_ready = 1'b1;
    while (ev_valid_o && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_bound", 64'(ev_valid_o), 64'd0);
    ev_ready = 1'b0;
  endtask

  int rx_base;
  int sent;
  int cyc;

  initial begin
    // Reset state
    do_reset();
    chk("rst_ev_valid", 64'(ev_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count_o), 64'd0);

    // Pass: two events, second is the tohost write
    ev_ready = 1'b0;
    do_store(32'h100, 32'hA);
    chk("pass_not_yet", 64'(pass_o), 64'd0);
    do_store(TOHOST, 32'd1);
    chk("pass_o", 64'(pass_o), 64'd1);
    chk("pass_done", 64'(done_o), 64'd1);
    chk("pass_head_addr", 64'(ev_addr_o), 64'h100);
    chk("pass_head_data", 64'(ev_data_o), 64'hA);
    rx_base = rx_count;
    ev_ready = 1'b1;
    tick();
    chk("pass_second_addr", 64'(ev_addr_o), 64'(TOHOST));
    drain(10);
    chk("pass_events", 64'(rx_count - rx_base), 64'd2);

    // Fail: code 3, later store ignored
    do_reset();
    do_store(TOHOST, 32'h7);
    chk("fail_o", 64'(fail_o), 64'd1);
    chk("fail_code", 64'(fail_code_o), 64'd3);
    do_store(32'h200, 32'h5);
    rx_base = rx_count;
    drain(10);
    chk("fail_events", 64'(rx_count - rx_base), 64'd1);

    // Even data to tohost is an ordinary store
    do_reset();
    do_store(TOHOST, 32'h4);
    chk("even_tohost_done", 64'(done_o), 64'd0);
    chk("even_tohost_event", 64'(ev_data_o), 64'h4);
    drain(10);

    // Watchdog with no stores
    do_reset();
    cyc = 0;
    while (!timeout_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("timeout_o", 64'(timeout_o), 64'd1);
    chk("timeout_cycle_count", 64'(cycle_count_o), 64'd50);
    tick();
    chk("timeout_frozen", 64'(cycle_count_o), 64'd50);

    // Tohost pass on the watchdog limit cycle wins
    do_reset();
    cyc = 0;
    while (cycle_count_o != 32'd49 && cyc < 100) begin
      tick();
      cyc++;
    end
    do_store(TOHOST, 32'd1);
    chk("limit_pass", 64'(pass_o), 64'd1);
    chk("limit_no_timeout", 64'(timeout_o), 64'd0);
    chk("limit_cycle_count", 64'(cycle_count_o), 64'd50);
    drain(10);

    // Overflow: 6 stores into a 4-deep FIFO with no consumer
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_store(32'h300 + 32'(i * 4), 32'(i));
    chk("ovf_drop_count", 64'(drop_count_o), 64'd2);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_head", 64'(ev_addr_o), 64'h300);
    ev_ready = 1'b1;
    do_store(32'h400, 32'h99);
    ev_ready = 1'b0;
    chk("ovf_push_pop_drops", 64'(drop_count_o), 64'd2);
    chk("ovf_push_pop_head", 64'(ev_addr_o), 64'h304);
    rx_base = rx_count;
    drain(20);
    chk("ovf_held_events", 64'(rx_count - rx_base), 64'd4);

    // Wrap-around: 20 stores with random consumer back-pressure
    do_reset();
    rx_base = rx_count;
    sent = 0;
    cyc = 0;
    while (sent < 20 && cyc < 200) begin
      ev_ready = (cyc > 25) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_q.size() < DEPTH) begin
        st_valid = 1'b1;
        st_addr  = 32'h1000 + 32'(sent * 4);
        st_data  = $urandom;
        sent++;
      end else begin
        st_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    st_valid = 1'b0;
    chk("wrap_sent", 64'(sent), 64'd20);
    drain(50);
    chk("wrap_received", 64'(rx_count - rx_base), 64'd20);
    chk("wrap_no_drops", 64'(drop_count_o), 64'd0);

    // Mid-run reset with queued events
    do_reset();
    ev_ready = 1'b0;
    do_store(32'h10, 32'h1);
    do_store(32'h14, 32'h2);
    do_store(TOHOST, 32'd1);
    chk("mid_pre_valid", 64'(ev_valid_o), 64'd1);
    chk("mid_pre_pass", 64'(pass_o), 64'd1);
    rst = 1'b1;
    ev_ready = 1'b1;
    tick();
    chk("mid_ev_valid", 64'(ev_valid_o), 64'd0);
    chk("mid_done", 64'(done_o), 64'd0);
    chk("mid_pass", 64'(pass_o), 64'd0);
    chk("mid_cycle_count", 64'(cycle_count_o), 64'd0);
    rst = 1'b0;
    ev_ready = 1'b0;
    do_store(TOHOST, 32'd1);
    chk("mid_run_again", 64'(pass_o), 64'd1);
    drain(10);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_store_monitor.md
RV_STORE_MONITOR -- requirements
Module: rv_store_monitor

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the store address/data width.
REQ-002 The block SHALL have parameter TOHOST_ADDR, default 32'h8000_0000, giving the completion mailbox address.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving the event FIFO depth (power of two, >= 2).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 200_000, giving the watchdog limit (0 disables the watchdog).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: clk_i (in, 1, clock) and rst_i (in, 1, synchronous active-high reset).
REQ-006 The block SHALL have the store-observation ports st_valid_i (in, 1, store this cycle), st_addr_i (in, XLEN, store address) and st_data_i (in, XLEN, store data).
REQ-007 The block SHALL have the event-output ports ev_valid_o (out, 1), ev_ready_i (in, 1), ev_addr_o (out, XLEN) and ev_data_o (out, XLEN), forming a valid/ready event stream.
REQ-008 The block SHALL have the status ports done_o, pass_o, fail_o, timeout_o, overflow_o (out, 1 each), fail_code_o (out, XLEN-1), cycle_count_o (out, 32) and drop_count_o (out, 16).

Function
REQ-009 The FSM SHALL have the states RUN, PASS, FAIL and TIMEOUT; RUN is entered on reset, and the other three are terminal until reset.
REQ-010 In RUN, a store with st_addr_i == TOHOST_ADDR and st_data_i == 1 SHALL move the FSM to PASS on the next cycle.
REQ-011 In RUN, a store to TOHOST_ADDR with st_data_i[0] == 1 and st_data_i != 1 SHALL move the FSM to FAIL and latch fail_code_o = st_data_i[XLEN-1:1].
REQ-012 A store to TOHOST_ADDR with st_data_i[0] == 0 SHALL NOT change state and SHALL be treated as an ordinary store.
REQ-013 done_o SHALL be high in any terminal state; pass_o, fail_o and timeout_o SHALL each be high only in their own state.
REQ-014 cycle_count_o SHALL increment once per cycle in RUN, saturate at 32'hFFFF_FFFF, and freeze in terminal states.
REQ-015 When TIMEOUT_CYCLES != 0 and cycle_count_o == TIMEOUT_CYCLES-1 in RUN with no terminating tohost store, the FSM SHALL enter TIMEOUT on the next cycle.
REQ-016 A terminating tohost store in the same cycle as the watchdog limit SHALL take priority, so the FSM goes to PASS or FAIL.
REQ-017 Every store accepted in RUN, including tohost stores, SHALL be pushed to the event FIFO; stores made in terminal states SHALL be ignored.
REQ-018 A push to an empty FIFO SHALL appear on ev_valid_o one cycle later, with no combinational bypass.
REQ-019 An event SHALL leave the FIFO when ev_valid_o && ev_ready_i; ev_addr_o and ev_data_o SHALL stay stable while ev_valid_o && !ev_ready_i.
REQ-020 When the FIFO is full, a push with a pop in the same cycle SHALL be accepted, keeping occupancy unchanged.
REQ-021 When the FIFO is full, a push with no pop SHALL be dropped, set overflow_o (sticky), and increment drop_count_o, saturating at 16'hFFFF.
REQ-022 A simultaneous push and pop on an empty FIFO SHALL accept the push only, because ev_valid_o is low.
REQ-023 Read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide, and full/empty SHALL be decoded from the MSB and the index bits so that wrap-around is correct.
REQ-024 Draining the FIFO SHALL continue in terminal states.

Reset
REQ-025 Under rst_i the state SHALL be RUN, all status outputs and counters SHALL be 0, fail_code_o SHALL be 0, the FIFO SHALL be empty and ev_valid_o SHALL be 0.
REQ-026 An rst_i asserted mid-operation SHALL discard queued events and clear sticky flags on the next edge, with no event output in that cycle.

Structure
REQ-027 The state enum, store_event_t and the default XLEN, TOHOST_ADDR and TIMEOUT_CYCLES constants SHALL live in the shared rv32i_tb_pkg.
REQ-028 The FIFO SHALL be a separate sub-module, rv_event_fifo, parametrised by width and depth, with push/pop/full/empty signals.

Verification
REQ-029 The bench SHALL cover pass: stores (0x100, 0xA), then (TOHOST_ADDR, 1) -> pass_o=1 and done_o=1 one cycle later, with 2 events drained in order.
REQ-030 The bench SHALL cover fail: store (TOHOST_ADDR, 0x7) -> fail_o=1 and fail_code_o=3; a later store to 0x200 produces no event.
REQ-031 The bench SHALL cover timeout: TIMEOUT_CYCLES=50 with no stores -> timeout_o=1 with cycle_count_o=50; a run with a (TOHOST_ADDR, 1) store on the limit cycle -> pass_o=1.
REQ-032 The bench SHALL cover overflow: FIFO_DEPTH=4, ev_ready_i=0, 6 stores -> 4 events held, overflow_o=1, drop_count_o=2; a full push with a pop keeps 4 events.
REQ-033 The bench SHALL cover wrap-around: 20 stores with random ev_ready_i -> all 20 received in order with matching addr/data.
REQ-034 The bench SHALL cover mid-run reset: 3 queued events then rst_i -> ev_valid_o=0, all status 0, and the state RUN.
